// File: rtl/hook_pkg.sv
// rtl/hook_pkg.sv - shared state encoding, swing LUTs and screen bounds for the hook engine
package hook_pkg;

   typedef enum logic [2:0] {
      SWING,
      EXTEND,
      RETRACT_EMPTY,
      RETRACT_LOADED,
      RETURN
   } hook_state_e;

   typedef logic signed [7:0] lut_t [0:31];

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   // Q1.7 entries, 5 degrees per index, index 16 is straight down (-80..+75 deg)
   localparam lut_t SIN_LUT = '{
      -8'sd125, -8'sd123, -8'sd119, -8'sd115, -8'sd110, -8'sd104, -8'sd97,  -8'sd90,
      -8'sd82,  -8'sd73,  -8'sd64,  -8'sd54,  -8'sd43,  -8'sd33,  -8'sd22,  -8'sd11,
      8'sd0,    8'sd11,   8'sd22,   8'sd33,   8'sd43,   8'sd54,   8'sd64,   8'sd73,
      8'sd82,   8'sd90,   8'sd97,   8'sd104,  8'sd110,  8'sd115,  8'sd119,  8'sd123
   };

   localparam lut_t COS_LUT = '{
      8'sd22,   8'sd33,   8'sd43,   8'sd54,   8'sd64,   8'sd73,   8'sd82,   8'sd90,
      8'sd97,   8'sd104,  8'sd110,  8'sd115,  8'sd119,  8'sd123,  8'sd125,  8'sd127,
      8'sd127,  8'sd127,  8'sd125,  8'sd123,  8'sd119,  8'sd115,  8'sd110,  8'sd104,
      8'sd97,   8'sd90,   8'sd82,   8'sd73,   8'sd64,   8'sd54,   8'sd43,   8'sd33
   };

endpackage

// File: rtl/hook_position.sv
// rtl/hook_position.sv - combinational angle/length to hook tip X/Y mapping
module hook_position
   import hook_pkg::*;
#(
   parameter int PIVOT_X = 320,
   parameter int PIVOT_Y = 64
) (
   input  logic [4:0]  angle_i,
   input  logic [8:0]  len_i,
   output logic [10:0] x_o,
   output logic [10:0] y_o
);

   logic signed [17:0] len_s;
   logic signed [17:0] sin_s;
   logic signed [17:0] cos_s;

   always_comb begin
      len_s = {9'b0, len_i};
      sin_s = {{10{SIN_LUT[angle_i][7]}}, SIN_LUT[angle_i]};
      cos_s = {{10{COS_LUT[angle_i][7]}}, COS_LUT[angle_i]};
   end

   // |len*lut| stays below 2^16, so the 18-bit product equals the 17-bit one
   assign x_o = 11'(PIVOT_X) + 11'((len_s * sin_s) >>> 7);
   assign y_o = 11'(PIVOT_Y) + 11'((len_s * cos_s) >>> 7);

endmodule

// File: rtl/hook_controller.sv
// rtl/hook_controller.sv - hook swing/extend/retract engine advancing on the frame tick
module hook_controller
   import hook_pkg::*;
#(
   parameter int PIVOT_X       = 320,
   parameter int PIVOT_Y       = 64,
   parameter int MIN_LEN       = 16,
   parameter int MAX_LEN       = 400,
   parameter int EXTEND_SPEED  = 4,
   parameter int RETRACT_SPEED = 8,
   parameter int SWING_DIV     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        startOfFrame,
   input  logic        fireKey,
   input  logic        collision,
   input  logic [1:0]  grabbedWeight,
   output logic [10:0] hookX,
   output logic [10:0] hookY,
   output logic        isHooked,
   output logic        hookReturned,
   output logic        busy
);

   localparam logic [8:0] MIN_L   = 9'(MIN_LEN);
   localparam logic [8:0] EXT_L   = 9'(EXTEND_SPEED);
   localparam logic [9:0] MAX_L   = 10'(MAX_LEN);
   localparam logic [8:0] RET_L   = 9'(RETRACT_SPEED);
   localparam logic [3:0] DIV_END = 4'(SWING_DIV - 1);

   hook_state_e state_q;
   logic [4:0]  angle_q;
   logic        dir_up_q;
   logic [8:0]  len_q;
   logic [3:0]  swing_cnt_q;
   logic [1:0]  weight_q;
   logic [10:0] hookX_q;
   logic [10:0] hookY_q;
   logic        isHooked_q;
   logic        hookReturned_q;

   logic [8:0]  len_ext_d;
   logic [9:0]  len_look_d;
   logic [8:0]  ret_step_d;
   logic [8:0]  len_ret_d;
   logic [10:0] pos_x, pos_y;
   logic [10:0] look_x, look_y;
   logic [10:0] rest_x, rest_y;
   logic        give_up_d;

   hook_position #(.PIVOT_X(PIVOT_X), .PIVOT_Y(PIVOT_Y)) u_pos (
      .angle_i (angle_q),
      .len_i   (len_q),
      .x_o     (pos_x),
      .y_o     (pos_y)
   );

   // Tip one extension step beyond the length written on this tick
   hook_position #(.PIVOT_X(PIVOT_X), .PIVOT_Y(PIVOT_Y)) u_look (
      .angle_i (angle_q),
      .len_i   (len_look_d[8:0]),
      .x_o     (look_x),
      .y_o     (look_y)
   );

   hook_position #(.PIVOT_X(PIVOT_X), .PIVOT_Y(PIVOT_Y)) u_rest (
      .angle_i (5'd16),
      .len_i   (MIN_L),
      .x_o     (rest_x),
      .y_o     (rest_y)
   );

   always_comb begin
      len_ext_d  = len_q + EXT_L;
      len_look_d = {1'b0, len_ext_d} + {1'b0, EXT_L};
      // Negative X wraps to a large unsigned value, so one compare covers both edges
      give_up_d  = (len_look_d >= MAX_L) || (look_x >= 11'(SCREEN_W)) ||
                   (look_y >= 11'(SCREEN_H));
      ret_step_d = RET_L;
      if (state_q == RETRACT_LOADED) begin
         ret_step_d = RET_L >> weight_q;
         if (ret_step_d == 9'd0) begin
            ret_step_d = 9'd1;
         end
      end
      if ({1'b0, len_q} <= {1'b0, MIN_L} + {1'b0, ret_step_d}) begin
         len_ret_d = MIN_L;
      end else begin
         len_ret_d = len_q - ret_step_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= SWING;
         angle_q        <= 5'd16;
         dir_up_q       <= 1'b1;
         len_q          <= MIN_L;
         swing_cnt_q    <= 4'd0;
         weight_q       <= 2'd0;
         hookX_q        <= rest_x;
         hookY_q        <= rest_y;
         isHooked_q     <= 1'b0;
         hookReturned_q <= 1'b0;
      end else begin
         hookX_q        <= pos_x;
         hookY_q        <= pos_y;
         hookReturned_q <= 1'b0;
         case (state_q)
            SWING: begin
               if (startOfFrame) begin
                  if (fireKey) begin
                     state_q <= EXTEND;
                  end else if (swing_cnt_q == DIV_END) begin
                     swing_cnt_q <= 4'd0;
                     // End index is held for one step while the direction flips
                     if (dir_up_q) begin
                        if (angle_q == 5'd31) dir_up_q <= 1'b0;
                        else                  angle_q  <= angle_q + 5'd1;
                     end else begin
                        if (angle_q == 5'd0)  dir_up_q <= 1'b1;
                        else                  angle_q  <= angle_q - 5'd1;
                     end
                  end else begin
                     swing_cnt_q <= swing_cnt_q + 4'd1;
                  end
               end
            end
            EXTEND: begin
               if (startOfFrame) begin
                  len_q <= len_ext_d;
                  if (collision) begin
                     state_q    <= RETRACT_LOADED;
                     isHooked_q <= 1'b1;
                     weight_q   <= grabbedWeight;
                  end else if (give_up_d) begin
                     state_q <= RETRACT_EMPTY;
                  end
               end
            end
            RETRACT_EMPTY: begin
               if (startOfFrame) begin
                  len_q <= len_ret_d;
                  if (len_ret_d == MIN_L) state_q <= SWING;
               end
            end
            RETRACT_LOADED: begin
               if (startOfFrame) begin
                  len_q <= len_ret_d;
                  if (len_ret_d == MIN_L) begin
                     state_q        <= RETURN;
                     hookReturned_q <= 1'b1;
                     isHooked_q     <= 1'b0;
                  end
               end
            end
            RETURN:  state_q <= SWING;
            default: state_q <= SWING;
         endcase
      end
   end

   assign hookX        = hookX_q;
   assign hookY        = hookY_q;
   assign isHooked     = isHooked_q;
   assign hookReturned = hookReturned_q;
   assign busy         = (state_q != SWING);

endmodule

// File: tb/tb_hook_controller.sv
// tb/tb_hook_controller.sv - directed self-checking bench for hook_controller
module tb_hook_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        startOfFrame = 1'b0;
   logic        fireKey = 1'b0;
   logic        collision = 1'b0;
   logic [1:0]  grabbedWeight = 2'd0;
   logic [10:0] hookX, hookY;
   logic        isHooked, hookReturned, busy;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses   = 0;

   hook_controller dut (
      .clk           (clk),
      .reset         (reset),
      .startOfFrame  (startOfFrame),
      .fireKey       (fireKey),
      .collision     (collision),
      .grabbedWeight (grabbedWeight),
      .hookX         (hookX),
      .hookY         (hookY),
      .isHooked      (isHooked),
      .hookReturned  (hookReturned),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (hookReturned === 1'b1) pulses++;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One frame tick, then one extra clock so the registered position has caught up
   task automatic tick();
      @(negedge clk) startOfFrame = 1'b1;
      @(negedge clk) startOfFrame = 1'b0;
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
   endtask

   initial begin
      // Reset state and freeze without ticks
      @(negedge clk) reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_x", hookX, 320);
      check("rst_y", hookY, 79);
      check("rst_hooked", isHooked, 0);
      check("rst_busy", busy, 0);
      check("rst_ret", hookReturned, 0);

      // Swing: step every 2 ticks, hold at 31, then head down
      collision = 1'b1;
      tick();
      check("swing_t1_x", hookX, 320);
      tick();
      check("swing_a17_x", hookX, 321);
      ticks(28);
      check("swing_a31_x", hookX, 335);
      ticks(2);
      check("swing_hold31_x", hookX, 335);
      ticks(2);
      check("swing_a30_x", hookX, 334);
      check("swing_busy", busy, 0);
      collision = 1'b0;

      // Empty shot at angle 16, fireKey held throughout
      do_reset();
      fireKey = 1'b1;
      tick();
      check("ext_busy", busy, 1);
      tick();
      check("ext_len20_y", hookY, 83);
      ticks(94);
      check("ext_len396_y", hookY, 456);
      tick();
      check("rete_len388_y", hookY, 448);
      ticks(46);
      check("rete_len20_busy", busy, 1);
      tick();
      check("rete_done_busy", busy, 0);
      check("rete_done_y", hookY, 79);
      check("rete_no_pulse", pulses, 0);
      check("rete_hooked", isHooked, 0);
      tick();
      check("relaunch_busy", busy, 1);
      fireKey = 1'b0;

      // Catch on 10th extend tick, weight 2 -> 2 px/frame
      do_reset();
      fireKey = 1'b1;
      tick();
      fireKey = 1'b0;
      ticks(9);
      collision = 1'b1;
      grabbedWeight = 2'd2;
      tick();
      collision = 1'b0;
      grabbedWeight = 2'd0;
      check("catch_hooked", isHooked, 1);
      check("catch_len56_y", hookY, 119);
      ticks(19);
      check("retl_len18_y", hookY, 81);
      check("retl_no_pulse_yet", pulses, 0);
      @(negedge clk) startOfFrame = 1'b1;
      @(negedge clk) startOfFrame = 1'b0;
      check("return_pulse", hookReturned, 1);
      check("return_unhooked", isHooked, 0);
      @(negedge clk);
      check("return_pulse_end", hookReturned, 0);
      check("return_busy", busy, 0);
      check("return_pulse_count", pulses, 1);

      // Collision and max length on the same tick, weight 3 -> 1 px/frame
      do_reset();
      fireKey = 1'b1;
      tick();
      fireKey = 1'b0;
      ticks(94);
      collision = 1'b1;
      grabbedWeight = 2'd3;
      tick();
      collision = 1'b0;
      check("tie_hooked", isHooked, 1);
      check("tie_len396_y", hookY, 456);
      tick();
      check("tie_len395_y", hookY, 455);
      ticks(378);
      check("tie_len17_busy", busy, 1);
      check("tie_pulse_before", pulses, 1);
      tick();
      check("tie_pulse_after", pulses, 2);
      check("tie_unhooked", isHooked, 0);
      check("tie_rest_y", hookY, 79);

      // Reset in the middle of a loaded retraction
      do_reset();
      fireKey = 1'b1;
      tick();
      fireKey = 1'b0;
      tick();
      collision = 1'b1;
      grabbedWeight = 2'd3;
      tick();
      collision = 1'b0;
      tick();
      check("mid_hooked", isHooked, 1);
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      check("mid_rst_x", hookX, 320);
      check("mid_rst_y", hookY, 79);
      check("mid_rst_hooked", isHooked, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ret", hookReturned, 0);
      repeat (3) @(negedge clk);
      check("mid_rst_pulses", pulses, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
